ogr_frame_rx: RTL

Upstream byte-to-frame assembler between the UART receiver and the ruler calculation control. Collects a fixed number of received bytes into one parallel input frame (max distance plus fixed-prefix marks). Presents the frame with a valid/ready handshake. Aborts partial frames on line errors or inter-byte timeout, and drops bytes that arrive while a completed frame is still unconsumed.

---
 rtl/ogr_frame_rx_if.sv | 31 +++
 rtl/ogr_frame_rx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ogr_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : ogr_frame_rx_if
// Description : Frame handshake bundle between the byte-to-frame assembler and
//               the ruler calculation control.
//               frame_data  - assembled frame, first byte in the top slot
//               frame_valid - frame_data holds a complete frame
//               frame_ready - consumer accepts the frame when high with valid
//               master: producer (assembler), slave: consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ogr_frame_rx_if #(
    parameter int FRAME_BYTES = 6
);
    logic [8*FRAME_BYTES-1:0] frame_data;
    logic                     frame_valid;
    logic                     frame_ready;

    modport master (
        output frame_data,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        output frame_ready
    );
endinterface
`default_nettype wire

// File: rtl/ogr_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : ogr_frame_rx
// Description : Collects FRAME_BYTES UART bytes into one parallel frame and
//               presents it with a valid/ready handshake. Partial frames are
//               aborted on a UART framing error or an inter-byte timeout;
//               bytes arriving while a finished frame waits are dropped.
// Ports       : clock, reset       - clock, async active-high reset
//               received, rx_byte  - byte strobe and data from the UART
//               recv_error         - UART framing error strobe
//               frame_if (master)  - frame_data / frame_valid / frame_ready
//               byte_count         - bytes held in the current frame
//               err_line/err_timeout/err_overrun - one-cycle error pulses
//               err_count          - saturating count of error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module ogr_frame_rx #(
    parameter  int FRAME_BYTES    = 6,
    parameter  int TIMEOUT_CYCLES = 25000,
    localparam int BCW            = $clog2(FRAME_BYTES + 1)
) (
    input  wire logic           clock,
    input  wire logic           reset,
    input  wire logic           received,
    input  wire logic [7:0]     rx_byte,
    input  wire logic           recv_error,
    ogr_frame_rx_if.master      frame_if,
    output logic [BCW-1:0]      byte_count,
    output logic                err_line,
    output logic                err_timeout,
    output logic                err_overrun,
    output logic [7:0]          err_count
);

    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TOP = 8*FRAME_BYTES - 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    state_t                   state_q,       state_d;
    logic [BCW-1:0]           count_q,       count_d;
    logic [TW-1:0]            timer_q,       timer_d;
    logic [8*FRAME_BYTES-1:0] frame_q,       frame_d;
    logic                     err_line_q,    err_line_d;
    logic                     err_timeout_q, err_timeout_d;
    logic                     err_overrun_q, err_overrun_d;
    logic [7:0]               err_count_q,   err_count_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            timer_q       <= '0;
            frame_q       <= '0;
            err_line_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            err_count_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            frame_q       <= frame_d;
            err_line_q    <= err_line_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
            err_count_q   <= err_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        timer_d       = timer_q;
        frame_d       = frame_q;
        err_line_d    = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        err_count_d   = err_count_q;

        // The count follows the registered pulses, so it steps one cycle
        // after each pulse is visible.
        if ((err_line_q || err_timeout_q || err_overrun_q) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                // A framing error with no partial frame has nothing to abort.
                if (received) begin
                    frame_d[TOP -: 8] = rx_byte;
                    count_d           = BCW'(1);
                    timer_d           = '0;
                    state_d           = (FRAME_BYTES == 1) ? S_FULL : S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (recv_error) begin
                    // Error beats a coincident byte: the byte is discarded too.
                    count_d    = '0;
                    timer_d    = '0;
                    err_line_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (received) begin
                    for (int i = 0; i < FRAME_BYTES; i++) begin
                        if (count_q == BCW'(i)) begin
                            frame_d[8*(FRAME_BYTES-1-i) +: 8] = rx_byte;
                        end
                    end
                    count_d = count_q + BCW'(1);
                    timer_d = '0;
                    if (count_q == BCW'(FRAME_BYTES - 1)) begin
                        state_d = S_FULL;
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // This idle cycle is the TIMEOUT_CYCLES-th since the last byte.
                    count_d       = '0;
                    timer_d       = '0;
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_FULL: begin
                if (frame_if.frame_ready) begin
                    if (received) begin
                        // Transfer and start the next frame in the same cycle.
                        frame_d[TOP -: 8] = rx_byte;
                        count_d           = BCW'(1);
                        timer_d           = '0;
                        state_d           = (FRAME_BYTES == 1) ? S_FULL : S_COLLECT;
                    end else begin
                        count_d = '0;
                        state_d = S_IDLE;
                    end
                end else if (received) begin
                    err_overrun_d = 1'b1;
                end
            end

            default: begin
                count_d = '0;
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign frame_if.frame_data  = frame_q;
    assign frame_if.frame_valid = (state_q == S_FULL);
    assign byte_count           = count_q;
    assign err_line             = err_line_q;
    assign err_timeout          = err_timeout_q;
    assign err_overrun          = err_overrun_q;
    assign err_count            = err_count_q;

endmodule
`default_nettype wire
